// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage constants and the fetch FSM state encoding.
// The decode/hazard unit imports this package as well.
package fetch_ctrl_pkg;

  localparam int          ADDR_W   = 64;
  localparam int          INSTR_W  = 32;
  localparam int          IMEM_AW  = 9;
  localparam logic [63:0] PC_INC   = 64'd1;
  localparam logic [63:0] RESET_PC = 64'd0;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding an instruction and its PC while decode stalls.
module fetch_skid_buf #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               load,
  input  logic               drain,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  logic               valid_reg;
  logic [INSTR_W-1:0] instr_reg;
  logic [ADDR_W-1:0]  pc_reg;

  // Occupancy: flush (redirect) beats load, load only happens while empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
    end else if (valid_reg && drain) begin
      valid_reg <= 1'b0;
    end
  end

  // Payload capture; contents are don't-care while the entry is empty.
  always_ff @(posedge clk) begin
    if (load) begin
      instr_reg <= in_instr;
      pc_reg    <= in_pc;
    end
  end

  assign valid     = valid_reg;
  assign out_instr = instr_reg;
  assign out_pc    = pc_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: steers the PC register, issues BRAM reads, and hands
// instructions to decode through a 1-entry skid buffer.
module fetch_ctrl #(
  parameter int                ADDR_W   = fetch_ctrl_pkg::ADDR_W,
  parameter int                INSTR_W  = fetch_ctrl_pkg::INSTR_W,
  parameter int                IMEM_AW  = fetch_ctrl_pkg::IMEM_AW,
  parameter logic [ADDR_W-1:0] PC_INC   = ADDR_W'(fetch_ctrl_pkg::PC_INC),
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(fetch_ctrl_pkg::RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  PC,
  output logic [ADDR_W-1:0]  PC_next,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic               halt_req,
  output logic               halted,
  output logic [31:0]        fetch_count
);

  import fetch_ctrl_pkg::*;

  fetch_state_e       state_reg, state_next;
  logic               inflight_reg;
  logic [ADDR_W-1:0]  fpc_reg;
  logic [31:0]        fetch_count_reg;
  logic               issue_en;
  logic               skid_v;
  logic               skid_load;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc;

  // BRAM registers this address itself; the data comes back next cycle.
  assign imem_addr = PC[IMEM_AW-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state, PC steering and issue decision. A redirect outranks halt
  // and any stall; issue waits until the skid is empty and the read in
  // flight (if any) is being consumed this cycle.
  always_comb begin
    state_next = state_reg;
    PC_next    = PC;
    issue_en   = 1'b0;
    case (state_reg)
      S_BOOT: begin
        PC_next    = RESET_PC;
        state_next = S_RUN;
      end
      S_RUN: begin
        if (br_taken) begin
          PC_next = br_target;
        end else begin
          issue_en = !skid_v && (!inflight_reg || if_ready);
          if (issue_en) begin
            PC_next = PC + PC_INC;
          end
          if (halt_req) begin
            state_next = S_HALT;
          end
        end
      end
      S_HALT: begin
        if (br_taken) begin
          PC_next    = br_target;
          state_next = S_RUN;
        end
      end
      default: begin
        state_next = S_BOOT;
      end
    endcase
    if (rst) begin
      PC_next = RESET_PC;
    end
  end

  // Track the outstanding BRAM read and the PC it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_reg <= 1'b0;
      fpc_reg      <= '0;
    end else begin
      inflight_reg <= issue_en;
      if (issue_en) begin
        fpc_reg <= PC;
      end
    end
  end

  // Park the returning read data when decode is not taking it.
  assign skid_load = inflight_reg && !skid_v && !if_ready && !br_taken;

  fetch_skid_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (br_taken),
    .load      (skid_load),
    .drain     (if_ready),
    .in_instr  (imem_rdata),
    .in_pc     (fpc_reg),
    .valid     (skid_v),
    .out_instr (skid_instr),
    .out_pc    (skid_pc)
  );

  // The skid entry is always older than the read in flight, so it goes first.
  assign if_valid = (skid_v || inflight_reg) && !br_taken && !rst;
  assign if_instr = skid_v ? skid_instr : imem_rdata;
  assign if_pc    = skid_v ? skid_pc : fpc_reg;
  assign halted   = (state_reg == S_HALT);

  // Count accepted transfers; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_reg <= '0;
    end else if (if_valid && if_ready) begin
      fetch_count_reg <= fetch_count_reg + 32'd1;
    end
  end

  assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC register and BRAM models around the DUT, a
// stimulus process, and a scoreboard that follows the instruction stream.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, if_ready, br_taken, halt_req;
  logic [63:0] PC, PC_next, br_target, if_pc;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata, if_instr, fetch_count;
  logic        if_valid, halted;

  logic [31:0] mem [512];
  logic [63:0] exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .PC          (PC),
    .PC_next     (PC_next),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .halt_req    (halt_req),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  initial begin
    for (int k = 0; k < 512; k++) mem[k] = 32'hA000_0000 + k;
  end

  // PC register and registered-read BRAM.
  always @(posedge clk) begin
    PC         <= PC_next;
    imem_rdata <= mem[imem_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return 32'hA000_0000 + {23'd0, pc[8:0]};
  endfunction

  // Scoreboard/monitor: samples on the falling edge, mid-cycle.
  initial begin
    logic        m_boot, m_halted, prev_stall;
    logic [63:0] prev_pc, e;
    int          m_count, due;
    m_boot = 1'b0; m_halted = 1'b0; prev_stall = 1'b0; prev_pc = '0;
    m_count = 0; due = -1;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("pc_next_in_reset", PC_next, 64'd0);
        exp_q.delete();
        exp_q.push_back(64'd0);
        m_boot = 1'b1; m_halted = 1'b0; m_count = 0; due = 3; prev_stall = 1'b0;
      end else if (m_boot) begin
        chk("boot_valid", {63'd0, if_valid}, 64'd0);
        chk("boot_pc_next", PC_next, 64'd0);
        chk("boot_halted", {63'd0, halted}, 64'd0);
        chk("boot_count", {32'd0, fetch_count}, 64'd0);
        m_boot = 1'b0; due = 2; prev_stall = 1'b0;
      end else begin
        chk("imem_addr", {55'd0, imem_addr}, {55'd0, PC[8:0]});
        chk("halted", {63'd0, halted}, {63'd0, m_halted});
        chk("fetch_count", {32'd0, fetch_count}, 64'(unsigned'(m_count)));
        if (prev_stall && !br_taken) begin
          chk("stall_hold_valid", {63'd0, if_valid}, 64'd1);
          chk("stall_hold_pc", if_pc, prev_pc);
        end
        if (if_valid && if_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL xfer_unexpected: got pc %h, expected none", if_pc);
          end else begin
            e = exp_q.pop_front();
            chk("xfer_pc", if_pc, e);
            chk("xfer_instr", {32'd0, if_instr}, {32'd0, instr_of(e)});
            exp_q.push_back(e + 64'd1);
          end
          m_count++;
        end
        if (br_taken) begin
          chk("redirect_valid", {63'd0, if_valid}, 64'd0);
          chk("redirect_pc_next", PC_next, br_target);
          exp_q.delete();
          exp_q.push_back(br_target);
          m_halted = 1'b0;
          due = 2;
        end else begin
          if (due > 0) begin
            due--;
            if (due == 0) begin
              chk("first_fetch_latency", {63'd0, if_valid}, 64'd1);
              due = -1;
            end else begin
              chk("fetch_bubble", {63'd0, if_valid}, 64'd0);
            end
          end
          if (m_halted) begin
            chk("halt_pc_frozen", PC_next, PC);
            if (!if_valid && exp_q.size() > 0) chk("halt_drained", exp_q[0], PC);
          end else begin
            n_tests++;
            if (PC_next !== PC && PC_next !== 64'(PC + 64'd1)) begin
              n_fail++;
              $display("FAIL run_pc_next: got %h, expected %h or %h", PC_next, PC, 64'(PC + 64'd1));
            end
            if (halt_req) m_halted = 1'b1;
          end
        end
        prev_stall = if_valid && !if_ready && !br_taken;
        prev_pc    = if_pc;
      end
    end
  end

  // One cycle of stimulus, applied just after the rising edge.
  task automatic step(input logic r, input logic rdy, input logic br, input logic h,
                      input logic [63:0] tgt);
    rst = r; if_ready = rdy; br_taken = br; halt_req = h; br_target = tgt;
    @(posedge clk);
    #1;
  endtask

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    step(1, 1, 0, 0, 64'd0);
    step(1, 1, 0, 0, 64'd0);
    repeat (6) step(0, 1, 0, 0, 64'd0);          // boot and stream
    repeat (3) step(0, 0, 0, 0, 64'd0);          // backpressure
    repeat (4) step(0, 1, 0, 0, 64'd0);
    repeat (2) step(0, 0, 0, 0, 64'd0);          // fill skid
    step(0, 0, 1, 0, 64'h40);                    // redirect with skid full
    repeat (5) step(0, 1, 0, 0, 64'd0);
    step(0, 1, 0, 1, 64'd0);                     // halt
    repeat (5) step(0, 1, 0, 0, 64'd0);
    step(0, 1, 1, 0, 64'h20);                    // restart
    repeat (4) step(0, 1, 0, 0, 64'd0);
    step(0, 1, 1, 1, 64'h80);                    // halt + redirect together
    repeat (3) step(0, 1, 0, 0, 64'd0);
    repeat (2) step(0, 0, 0, 0, 64'd0);          // stall, skid full
    step(1, 0, 0, 0, 64'd0);                     // reset mid-stream
    repeat (6) step(0, 1, 0, 0, 64'd0);
    step(0, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE);   // approach wrap
    repeat (5) step(0, 1, 0, 0, 64'd0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 200) == 0, ($urandom % 10) < 7, ($urandom % 25) == 0,
           ($urandom % 30) == 0, {$urandom, $urandom});
    end
    repeat (3) step(0, 1, 0, 0, 64'd0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
